// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU reads and LSU reads/writes.
// One transaction in flight; response strobe no earlier than 3 cycles after accept; ready only in IDLE.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rsp_data,
  output logic                ifu_rsp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic                lsu_wen,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_data,
  output logic                lsu_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_wen,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data
);

  localparam int MASK_W = DATA_W / 8;
  localparam int WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wen_q, wen_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [DATA_W-1:0]   ifu_data_q, ifu_data_d;
  logic                ifu_err_q, ifu_err_d;
  logic [DATA_W-1:0]   lsu_data_q, lsu_data_d;
  logic                lsu_err_q, lsu_err_d;

  logic                ifu_win, lsu_win;
  logic [WD_W-1:0]     wd_nxt;

  // On a tie the requester that was not granted last time wins.
  assign ifu_win = ifu_req_valid && (!lsu_req_valid || (last_grant_q == OWN_LSU));
  assign lsu_win = lsu_req_valid && !ifu_win;
  assign wd_nxt  = wd_q + WD_W'(1);

  assign ifu_req_ready = (state_q == S_IDLE) && ifu_win;
  assign lsu_req_ready = (state_q == S_IDLE) && lsu_win;

  assign mem_req_valid = (state_q == S_REQ);
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wen       = wen_q;
  assign mem_wmask     = wmask_q;

  assign ifu_rsp_valid = (state_q == S_RESP) && (owner_q == OWN_IFU);
  assign lsu_rsp_valid = (state_q == S_RESP) && (owner_q == OWN_LSU);
  assign ifu_rsp_data  = ifu_data_q;
  assign ifu_rsp_err   = ifu_err_q;
  assign lsu_rsp_data  = lsu_data_q;
  assign lsu_rsp_err   = lsu_err_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wen_d        = wen_q;
    wmask_d      = wmask_q;
    wd_d         = wd_q;
    ifu_data_d   = ifu_data_q;
    ifu_err_d    = ifu_err_q;
    lsu_data_d   = lsu_data_q;
    lsu_err_d    = lsu_err_q;

    case (state_q)
      S_IDLE: begin
        if (ifu_win) begin
          state_d      = S_REQ;
          last_grant_d = OWN_IFU;
          owner_d      = OWN_IFU;
          addr_d       = ifu_addr;
          wdata_d      = '0;
          wen_d        = 1'b0;
          wmask_d      = '0;
        end else if (lsu_win) begin
          state_d      = S_REQ;
          last_grant_d = OWN_LSU;
          owner_d      = OWN_LSU;
          addr_d       = lsu_addr;
          wdata_d      = lsu_wdata;
          wen_d        = lsu_wen;
          wmask_d      = lsu_wen ? lsu_wmask : '0;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
          wd_d    = '0;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          state_d = S_RESP;
          if (owner_q == OWN_IFU) begin
            ifu_data_d = mem_rsp_data;
            ifu_err_d  = 1'b0;
          end else begin
            lsu_data_d = mem_rsp_data;
            lsu_err_d  = 1'b0;
          end
        end else if (TIMEOUT != 0) begin
          wd_d = wd_nxt;
          // Counter reaches TIMEOUT on the transition out, so it never wraps.
          if (wd_nxt == WD_W'(TIMEOUT)) begin
            state_d = S_RESP;
            if (owner_q == OWN_IFU) begin
              ifu_data_d = '0;
              ifu_err_d  = 1'b1;
            end else begin
              lsu_data_d = '0;
              lsu_err_d  = 1'b1;
            end
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= OWN_LSU;
      owner_q      <= OWN_IFU;
      addr_q       <= '0;
      wdata_q      <= '0;
      wen_q        <= 1'b0;
      wmask_q      <= '0;
      wd_q         <= '0;
      ifu_data_q   <= '0;
      ifu_err_q    <= 1'b0;
      lsu_data_q   <= '0;
      lsu_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wen_q        <= wen_d;
      wmask_q      <= wmask_d;
      wd_q         <= wd_d;
      ifu_data_q   <= ifu_data_d;
      ifu_err_q    <= ifu_err_d;
      lsu_data_q   <= lsu_data_d;
      lsu_err_q    <= lsu_err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with TIMEOUT=4; inputs change and outputs are sampled on the falling edge.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic        ifu_rsp_err;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_wen;
  logic [3:0]  lsu_wmask;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rsp_data;
  logic        lsu_rsp_err;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_wen;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  int errs;
  int checks;
  bit both_seen;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wen(lsu_wen), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (ifu_req_ready && lsu_req_ready) both_seen = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  // Memory-side driver only: answers one request with data d one cycle after the handshake.
  task automatic mem_serve(input logic [31:0] d, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (mem_req_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (mem_req_valid === 1'b1) begin
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = d;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wen = 0; lsu_wmask = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_req_valid !== 0 || mem_addr !== 0 || mem_wdata !== 0 || mem_wen !== 0 || mem_wmask !== 0)
      begin errs++; $display("FAIL reset_mem: valid=%b addr=%h wdata=%h wen=%b wmask=%b, required all 0",
                             mem_req_valid, mem_addr, mem_wdata, mem_wen, mem_wmask); end
    checks++;
    if (ifu_rsp_valid !== 0 || ifu_rsp_data !== 0 || ifu_rsp_err !== 0 ||
        lsu_rsp_valid !== 0 || lsu_rsp_data !== 0 || lsu_rsp_err !== 0)
      begin errs++; $display("FAIL reset_rsp: ifu v/d/e=%b/%h/%b lsu v/d/e=%b/%h/%b, required all 0",
                             ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err); end
    rst = 1'b0;
  endtask

  task automatic test_ifu_read();
    @(negedge clk);
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
    #1;
    checks++;
    if (ifu_req_ready !== 1 || lsu_req_ready !== 0)
      begin errs++; $display("FAIL ifu_ready: ifu=%b lsu=%b, required 1/0", ifu_req_ready, lsu_req_ready); end
    @(negedge clk);
    ifu_req_valid = 0; ifu_addr = 0;
    checks++;
    if (mem_req_valid !== 1 || mem_addr !== 32'h8000_0000 || mem_wen !== 0 || mem_wmask !== 0)
      begin errs++; $display("FAIL ifu_memreq: valid=%b addr=%h wen=%b wmask=%b, required 1/80000000/0/0",
                             mem_req_valid, mem_addr, mem_wen, mem_wmask); end
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h0000_0413;
    checks++;
    if (mem_req_valid !== 0 || ifu_rsp_valid !== 0)
      begin errs++; $display("FAIL ifu_wait: mem_req_valid=%b ifu_rsp_valid=%b, required 0/0", mem_req_valid, ifu_rsp_valid); end
    @(negedge clk);
    mem_rsp_valid = 0;
    checks++;
    if (ifu_rsp_valid !== 1 || ifu_rsp_data !== 32'h0000_0413 || ifu_rsp_err !== 0 || lsu_rsp_valid !== 0)
      begin errs++; $display("FAIL ifu_rsp: v=%b d=%h e=%b lsu_v=%b, required 1/00000413/0/0",
                             ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err, lsu_rsp_valid); end
    @(negedge clk);
    checks++;
    if (ifu_rsp_valid !== 0 || ifu_rsp_data !== 32'h0000_0413 || lsu_rsp_valid !== 0)
      begin errs++; $display("FAIL ifu_rsp_hold: v=%b d=%h lsu_v=%b, required 0/00000413/0",
                             ifu_rsp_valid, ifu_rsp_data, lsu_rsp_valid); end
  endtask

  task automatic test_lsu_write();
    @(negedge clk);
    lsu_req_valid = 1; lsu_addr = 32'h8000_0100; lsu_wdata = 32'hDEAD_BEEF; lsu_wen = 1; lsu_wmask = 4'b0011;
    #1;
    checks++;
    if (lsu_req_ready !== 1 || ifu_req_ready !== 0)
      begin errs++; $display("FAIL lsu_ready: lsu=%b ifu=%b, required 1/0", lsu_req_ready, ifu_req_ready); end
    @(negedge clk);
    lsu_req_valid = 0; lsu_wen = 0; lsu_wmask = 0;
    checks++;
    if (mem_req_valid !== 1 || mem_addr !== 32'h8000_0100 || mem_wdata !== 32'hDEAD_BEEF ||
        mem_wen !== 1 || mem_wmask !== 4'b0011)
      begin errs++; $display("FAIL lsu_memreq: v=%b a=%h wd=%h wen=%b wm=%b, required 1/80000100/deadbeef/1/0011",
                             mem_req_valid, mem_addr, mem_wdata, mem_wen, mem_wmask); end
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h0000_1234;
    @(negedge clk);
    mem_rsp_valid = 0;
    checks++;
    if (lsu_rsp_valid !== 1 || lsu_rsp_err !== 0 || lsu_rsp_data !== 32'h0000_1234 || ifu_rsp_valid !== 0)
      begin errs++; $display("FAIL lsu_wrsp: v=%b e=%b d=%h ifu_v=%b, required 1/0/00001234/0",
                             lsu_rsp_valid, lsu_rsp_err, lsu_rsp_data, ifu_rsp_valid); end
    @(negedge clk);
    checks++;
    if (lsu_rsp_valid !== 0)
      begin errs++; $display("FAIL lsu_wrsp_pulse: v=%b, required 0", lsu_rsp_valid); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int grant;
    int exp_grant;
    logic [31:0] d;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    both_seen = 0;
    ifu_addr = 32'h8000_1000; lsu_addr = 32'h8000_2000; lsu_wen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ifu_req_valid = 1; lsu_req_valid = 1;
      #1;
      grant = ifu_req_ready ? 0 : (lsu_req_ready ? 1 : 2);
      exp_grant = i % 2;
      checks++;
      if (grant !== exp_grant)
        begin errs++; $display("FAIL rr_grant%0d: grant=%0d, required %0d (0=ifu 1=lsu)", i, grant, exp_grant); end
      d = 32'hA000_0000 + i;
      mem_serve(d, ok);
      checks++;
      if (!ok)
        begin errs++; $display("FAIL rr_memreq%0d: mem_req_valid not seen, required within 20 cycles", i); end
      checks++;
      if (exp_grant == 0 ? (ifu_rsp_valid !== 1 || ifu_rsp_data !== d || lsu_rsp_valid !== 0)
                         : (lsu_rsp_valid !== 1 || lsu_rsp_data !== d || ifu_rsp_valid !== 0))
        begin errs++; $display("FAIL rr_rsp%0d: ifu_v=%b ifu_d=%h lsu_v=%b lsu_d=%h, required owner %0d data %h",
                               i, ifu_rsp_valid, ifu_rsp_data, lsu_rsp_valid, lsu_rsp_data, exp_grant, d); end
    end
    ifu_req_valid = 0; lsu_req_valid = 0;
    checks++;
    if (both_seen)
      begin errs++; $display("FAIL rr_both_ready: both readies seen high, required never"); end
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    @(negedge clk);
    ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
    @(negedge clk);
    ifu_req_valid = 0;
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    n = 0;
    while (ifu_rsp_valid !== 1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 4)
      begin errs++; $display("FAIL to_latency: rsp after %0d wait cycles, required 4", n); end
    checks++;
    if (ifu_rsp_valid !== 1 || ifu_rsp_err !== 1 || ifu_rsp_data !== 0 || lsu_rsp_valid !== 0)
      begin errs++; $display("FAIL to_rsp: v=%b e=%b d=%h lsu_v=%b, required 1/1/00000000/0",
                             ifu_rsp_valid, ifu_rsp_err, ifu_rsp_data, lsu_rsp_valid); end
    @(negedge clk);
    mem_rsp_valid = 1; mem_rsp_data = 32'h0BAD_0BAD;
    @(negedge clk);
    mem_rsp_valid = 0;
    checks++;
    if (ifu_rsp_valid !== 0 || lsu_rsp_valid !== 0 || mem_req_valid !== 0 || ifu_rsp_err !== 1 || ifu_rsp_data !== 0)
      begin errs++; $display("FAIL to_late_ignored: ifu_v=%b lsu_v=%b mreq=%b e=%b d=%h, required 0/0/0/1/00000000",
                             ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, ifu_rsp_err, ifu_rsp_data); end
    lsu_req_valid = 1; lsu_addr = 32'h8000_0080; lsu_wen = 0;
    @(negedge clk);
    lsu_req_valid = 0;
    mem_serve(32'h0000_55AA, ok);
    checks++;
    if (!ok || lsu_rsp_valid !== 1 || lsu_rsp_err !== 0 || lsu_rsp_data !== 32'h0000_55AA)
      begin errs++; $display("FAIL to_next_req: ok=%b v=%b e=%b d=%h, required 1/1/0/000055aa",
                             ok, lsu_rsp_valid, lsu_rsp_err, lsu_rsp_data); end
  endtask

  task automatic test_req_stall();
    int bad;
    @(negedge clk);
    lsu_req_valid = 1; lsu_addr = 32'h8000_0200; lsu_wen = 0;
    @(negedge clk);
    lsu_req_valid = 0; lsu_addr = 32'h0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req_valid !== 1 || mem_addr !== 32'h8000_0200) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0)
      begin errs++; $display("FAIL stall_stable: %0d unstable cycles, required 0", bad); end
    // Response in the same cycle as the handshake must be dropped.
    mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_data = 32'hBADB_AD00;
    @(negedge clk);
    mem_req_ready = 0; mem_rsp_valid = 0;
    checks++;
    if (lsu_rsp_valid !== 0 || mem_req_valid !== 0)
      begin errs++; $display("FAIL stall_same_cycle_rsp: lsu_v=%b mreq=%b, required 0/0", lsu_rsp_valid, mem_req_valid); end
    repeat (3) @(negedge clk);
    // Fourth WAIT cycle: a real response still beats the watchdog.
    mem_rsp_valid = 1; mem_rsp_data = 32'h0000_0077;
    @(negedge clk);
    mem_rsp_valid = 0;
    checks++;
    if (lsu_rsp_valid !== 1 || lsu_rsp_err !== 0 || lsu_rsp_data !== 32'h0000_0077)
      begin errs++; $display("FAIL stall_rsp: v=%b e=%b d=%h, required 1/0/00000077",
                             lsu_rsp_valid, lsu_rsp_err, lsu_rsp_data); end
  endtask

  task automatic test_reset_mid_wait();
    int pulses;
    @(negedge clk);
    ifu_req_valid = 1; ifu_addr = 32'h8000_0300;
    @(negedge clk);
    ifu_req_valid = 0;
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    #2 rst = 1;
    #1;
    checks++;
    if (mem_req_valid !== 0 || mem_addr !== 0 || ifu_rsp_err !== 0 || ifu_rsp_data !== 0 ||
        lsu_rsp_data !== 0 || lsu_rsp_err !== 0)
      begin errs++; $display("FAIL rst_async: mreq=%b a=%h ifu_e=%b ifu_d=%h lsu_d=%h lsu_e=%b, required all 0",
                             mem_req_valid, mem_addr, ifu_rsp_err, ifu_rsp_data, lsu_rsp_data, lsu_rsp_err); end
    @(negedge clk);
    rst = 0;
    mem_rsp_valid = 1; mem_rsp_data = 32'h1111_2222;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_rsp_valid = 0;
      if (ifu_rsp_valid !== 0 || lsu_rsp_valid !== 0) pulses++;
    end
    checks++;
    if (pulses !== 0)
      begin errs++; $display("FAIL rst_no_rsp: %0d response cycles, required 0", pulses); end
    ifu_req_valid = 1; lsu_req_valid = 1; ifu_addr = 32'h8000_0400; lsu_addr = 32'h8000_0500;
    #1;
    checks++;
    if (ifu_req_ready !== 1 || lsu_req_ready !== 0)
      begin errs++; $display("FAIL rst_tie: ifu=%b lsu=%b, required 1/0", ifu_req_ready, lsu_req_ready); end
    @(negedge clk);
    ifu_req_valid = 0; lsu_req_valid = 0;
  endtask

  initial begin
    errs = 0;
    checks = 0;
    both_seen = 0;
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_round_robin();
    test_timeout();
    test_req_stall();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
